// File: rtl/sdram_scheduler_pkg.sv
// Shared definitions for the SDRAM command-bus scheduler.
//   - SDRAM command codes ({RAS_n, CAS_n, WE_n}) used by the scheduler itself
//   - default refresh recovery time
//   - arbiter state encoding
//   - saturating increment for the grant-time counter
package sdram_scheduler_pkg;

  localparam logic [2:0] SDRAM_CMD_NOP = 3'b111;
  localparam logic [2:0] SDRAM_CMD_AR  = 3'b001;

  localparam int T_RFC_DEFAULT = 7;
  localparam int GRANT_CNT_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REFRESH    = 3'd1,
    ST_GRANT_WR   = 3'd2,
    ST_RELEASE_WR = 3'd3,
    ST_GRANT_RD   = 3'd4,
    ST_RELEASE_RD = 3'd5
  } sched_state_e;

  // Grant counter holds at all-ones instead of wrapping, so a very long
  // uncontended grant can never look "fresh" again.
  function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
    return (&v) ? v : v + GRANT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sdram_scheduler_refresh_timer.sv
// Periodic auto-refresh request generator.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   run      in   count enable (SDRAM initialisation complete)
//   clr      in   refresh has been serviced (by scheduler AR or engine pulse)
//   pending  out  a refresh is owed to the SDRAM
//   overrun  out  one-cycle pulse: interval expired while a refresh was still owed
module sdram_scheduler_refresh_timer #(
  parameter int REFRESH_INTERVAL = 1560
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic pending,
  output logic overrun
);

  localparam int            TW     = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          expire;

  always_comb begin
    expire    = run && (timer_q == '0);
    timer_d   = timer_q;
    if (run) begin
      timer_d = expire ? RELOAD : timer_q - TW'(1);
    end
    // A new expiry wins over a same-cycle clear: that is a fresh refresh owed.
    pending_d = pending_q;
    if (clr) begin
      pending_d = 1'b0;
    end
    if (expire) begin
      pending_d = 1'b1;
    end
    // Only one refresh is remembered; a second expiry on top of it is lost.
    overrun_d = expire && pending_q && !clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/sdram_scheduler.sv
// SDRAM command-bus scheduler: shares the single pad-side command bus between
// the write engine and the read engine with round-robin arbitration and a
// bounded grant time, and keeps the periodic auto-refresh going (pulsed to
// the granted engine, or issued directly when the bus is idle).
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   init_done                SDRAM power-up sequence complete
//   wr_req/rd_req            engine has work queued
//   wr_en/rd_en              engine enable (owns bus while enabled)
//   wr_ready/rd_ready        engine idle, nothing in flight
//   wr_auto_refresh/rd_...   one-cycle refresh request to the granted engine
//   wr_/rd_command,addr,bank engine-side SDRAM bus
//   sdram_command,addr,bank  muxed pad-side SDRAM bus
//   busy                     arbiter not idle
//   refresh_overrun          one-cycle pulse on a lost refresh
module sdram_scheduler
  import sdram_scheduler_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 1560,
  parameter int T_RFC            = T_RFC_DEFAULT,
  parameter int MAX_GRANT        = 4096,
  parameter int WR_FIRST         = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic        wr_auto_refresh,
  input  logic [2:0]  wr_command,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_ready,
  output logic        rd_auto_refresh,
  input  logic [2:0]  rd_command,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic [2:0]  sdram_command,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        busy,
  output logic        refresh_overrun
);

  localparam int                     RW          = (T_RFC > 1) ? $clog2(T_RFC) : 1;
  localparam logic [RW-1:0]          RFC_LOAD    = RW'(T_RFC - 1);
  localparam logic [GRANT_CNT_W-1:0] GRANT_LIMIT = GRANT_CNT_W'(MAX_GRANT - 1);

  sched_state_e           state_q, state_d;
  logic [GRANT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [RW-1:0]          rfc_cnt_q, rfc_cnt_d;
  logic                   last_wr_q, last_wr_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_ar_q, wr_ar_d;
  logic                   rd_ar_q, rd_ar_d;
  logic                   busy_q, busy_d;
  logic [2:0]             cmd_q, cmd_d;

  logic refresh_pending;
  logic refresh_clr;

  // Serviced either by our own AR (its single cycle on the bus) or by the
  // cycle the granted engine sees its auto_refresh pulse.
  assign refresh_clr = wr_ar_q | rd_ar_q | ((state_q == ST_REFRESH) && (cmd_q == SDRAM_CMD_AR));

  sdram_scheduler_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (init_done),
    .clr     (refresh_clr),
    .pending (refresh_pending),
    .overrun (refresh_overrun)
  );

  // Next-state and next-output logic; every output below is registered.
  always_comb begin
    state_d     = state_q;
    grant_cnt_d = grant_cnt_q;
    rfc_cnt_d   = rfc_cnt_q;
    last_wr_d   = last_wr_q;

    case (state_q)
      ST_IDLE: begin
        // Decision uses the pending value from before any same-cycle expiry.
        if (init_done) begin
          if (refresh_pending) begin
            state_d   = ST_REFRESH;
            rfc_cnt_d = RFC_LOAD;
          end else if (wr_req && (!rd_req || !last_wr_q)) begin
            state_d     = ST_GRANT_WR;
            grant_cnt_d = '0;
            last_wr_d   = 1'b1;
          end else if (rd_req) begin
            state_d     = ST_GRANT_RD;
            grant_cnt_d = '0;
            last_wr_d   = 1'b0;
          end
        end
      end
      ST_REFRESH: begin
        if (rfc_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          rfc_cnt_d = rfc_cnt_q - RW'(1);
        end
      end
      ST_GRANT_WR: begin
        grant_cnt_d = sat_inc(grant_cnt_q);
        if (!wr_req || ((grant_cnt_q >= GRANT_LIMIT) && rd_req)) begin
          state_d = ST_RELEASE_WR;
        end
      end
      ST_RELEASE_WR: begin
        if (wr_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_RD: begin
        grant_cnt_d = sat_inc(grant_cnt_q);
        if (!rd_req || ((grant_cnt_q >= GRANT_LIMIT) && wr_req)) begin
          state_d = ST_RELEASE_RD;
        end
      end
      ST_RELEASE_RD: begin
        if (rd_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_en_d = (state_d == ST_GRANT_WR);
    rd_en_d = (state_d == ST_GRANT_RD);
    busy_d  = (state_d != ST_IDLE);
    cmd_d   = ((state_q == ST_IDLE) && (state_d == ST_REFRESH)) ? SDRAM_CMD_AR : SDRAM_CMD_NOP;

    // Pulse only while the grant continues (engine ignores it once en drops);
    // the !ar_q term keeps it to one cycle while pending is being cleared.
    wr_ar_d = (state_q == ST_GRANT_WR) && (state_d == ST_GRANT_WR) && refresh_pending && !wr_ar_q;
    rd_ar_d = (state_q == ST_GRANT_RD) && (state_d == ST_GRANT_RD) && refresh_pending && !rd_ar_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_cnt_q <= '0;
      rfc_cnt_q   <= '0;
      last_wr_q   <= (WR_FIRST == 0);
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_ar_q     <= 1'b0;
      rd_ar_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_q       <= SDRAM_CMD_NOP;
    end else begin
      state_q     <= state_d;
      grant_cnt_q <= grant_cnt_d;
      rfc_cnt_q   <= rfc_cnt_d;
      last_wr_q   <= last_wr_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wr_ar_q     <= wr_ar_d;
      rd_ar_q     <= rd_ar_d;
      busy_q      <= busy_d;
      cmd_q       <= cmd_d;
    end
  end

  assign wr_en           = wr_en_q;
  assign rd_en           = rd_en_q;
  assign wr_auto_refresh = wr_ar_q;
  assign rd_auto_refresh = rd_ar_q;
  assign busy            = busy_q;

  // The engine keeps the bus through RELEASE so its closing precharge/AR
  // reaches the pads; the scheduler's own AR carries addr/bank of zero.
  always_comb begin
    sdram_command = cmd_q;
    sdram_addr    = '0;
    sdram_bank    = '0;
    case (state_q)
      ST_GRANT_WR, ST_RELEASE_WR: begin
        sdram_command = wr_command;
        sdram_addr    = wr_addr;
        sdram_bank    = wr_bank;
      end
      ST_GRANT_RD, ST_RELEASE_RD: begin
        sdram_command = rd_command;
        sdram_addr    = rd_addr;
        sdram_bank    = rd_bank;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_scheduler.sv
module tb_sdram_scheduler;
  import sdram_scheduler_pkg::*;

  localparam logic [2:0]  WCMD  = 3'b100;
  localparam logic [11:0] WADDR = 12'hA5A;
  localparam logic [1:0]  WBANK = 2'b01;
  localparam logic [2:0]  RCMD  = 3'b101;
  localparam logic [11:0] RADDR = 12'h5C3;
  localparam logic [1:0]  RBANK = 2'b10;

  typedef struct packed {
    logic        wr_en;
    logic        rd_en;
    logic        wr_ar;
    logic        rd_ar;
    logic        busy;
    logic        ovr;
    logic [2:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  bank;
  } obs_t;

  typedef struct packed {
    logic [1:0] side;
    logic [7:0] start;
    logic [7:0] len;
  } grant_t;

  logic clk, rst, init_done;
  logic wr_req, wr_ready, rd_req, rd_ready;
  logic [2:0]  wr_command, rd_command;
  logic [11:0] wr_addr, rd_addr;
  logic [1:0]  wr_bank, rd_bank;

  logic a_wr_en, a_rd_en, a_wr_ar, a_rd_ar, a_busy, a_ovr;
  logic [2:0] a_cmd; logic [11:0] a_addr; logic [1:0] a_bank;
  logic r_wr_en, r_rd_en, r_wr_ar, r_rd_ar, r_busy, r_ovr;
  logic [2:0] r_cmd; logic [11:0] r_addr; logic [1:0] r_bank;

  int checks = 0;
  int failures = 0;
  obs_t   exp_q[$];
  grant_t grant_q[$];

  // Arbitration instance: refresh effectively never fires during the run.
  sdram_scheduler #(.REFRESH_INTERVAL(50000), .T_RFC(7), .MAX_GRANT(8), .WR_FIRST(1)) u_arb (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .wr_en(a_wr_en), .wr_ready(wr_ready), .wr_auto_refresh(a_wr_ar),
    .wr_command(wr_command), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_en(a_rd_en), .rd_ready(rd_ready), .rd_auto_refresh(a_rd_ar),
    .rd_command(rd_command), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .sdram_command(a_cmd), .sdram_addr(a_addr), .sdram_bank(a_bank),
    .busy(a_busy), .refresh_overrun(a_ovr)
  );

  // Refresh instance: 20-cycle refresh interval.
  sdram_scheduler #(.REFRESH_INTERVAL(20), .T_RFC(7), .MAX_GRANT(8), .WR_FIRST(1)) u_ref (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .wr_en(r_wr_en), .wr_ready(wr_ready), .wr_auto_refresh(r_wr_ar),
    .wr_command(wr_command), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_en(r_rd_en), .rd_ready(rd_ready), .rd_auto_refresh(r_rd_ar),
    .rd_command(rd_command), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .sdram_command(r_cmd), .sdram_addr(r_addr), .sdram_bank(r_bank),
    .busy(r_busy), .refresh_overrun(r_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic obs_t obs_a();
    obs_t o;
    o = {a_wr_en, a_rd_en, a_wr_ar, a_rd_ar, a_busy, a_ovr, a_cmd, a_addr, a_bank};
    return o;
  endfunction

  function automatic obs_t obs_r();
    obs_t o;
    o = {r_wr_en, r_rd_en, r_wr_ar, r_rd_ar, r_busy, r_ovr, r_cmd, r_addr, r_bank};
    return o;
  endfunction

  // owner: 0 = scheduler (NOP, or AR when ar=1), 1 = write engine, 2 = read engine
  function automatic obs_t mk(input logic wen, input logic ren, input logic war, input logic rar,
                              input logic bsy, input logic ovr, input int owner, input logic ar);
    obs_t o;
    o.wr_en = wen; o.rd_en = ren; o.wr_ar = war; o.rd_ar = rar; o.busy = bsy; o.ovr = ovr;
    case (owner)
      1:       begin o.cmd = WCMD; o.addr = WADDR; o.bank = WBANK; end
      2:       begin o.cmd = RCMD; o.addr = RADDR; o.bank = RBANK; end
      default: begin o.cmd = ar ? SDRAM_CMD_AR : SDRAM_CMD_NOP; o.addr = '0; o.bank = '0; end
    endcase
    return o;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with rst just released; next posedge is cycle 1.
  task automatic do_reset(input logic init);
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_ready = 1'b1; rd_ready = 1'b1; init_done = init;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
    got = obs_a(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_async_arb got=%h exp=%h", got, exp); end
    got = obs_r(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_async_ref got=%h exp=%h", got, exp); end
    init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    @(posedge clk); #1;
    got = obs_a(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_held_arb got=%h exp=%h", got, exp); end
    got = obs_r(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_held_ref got=%h exp=%h", got, exp); end
  endtask

  task automatic test_init_gate();
    obs_t got, exp;
    do_reset(1'b0);
    for (int c = 1; c <= 30; c++) begin
      wr_req = 1'b1; rd_req = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      cycle();
      exp = exp_q.pop_front();
      got = obs_r(); checks++;
      if (got !== exp) begin failures++; $display("FAIL init_gate_ref c=%0d got=%h exp=%h", c, got, exp); end
      got = obs_a(); checks++;
      if (got !== exp) begin failures++; $display("FAIL init_gate_arb c=%0d got=%h exp=%h", c, got, exp); end
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_refresh_period();
    obs_t got, exp;
    logic ar, bsy;
    do_reset(1'b1);
    for (int c = 1; c <= 65; c++) begin
      ar  = (c >= 21) && (((c - 21) % 20) == 0);
      bsy = (c >= 21) && (((c - 21) % 20) < 7);
      exp_q.push_back(mk(0, 0, 0, 0, bsy, 0, 0, ar));
      cycle();
      exp = exp_q.pop_front();
      got = obs_r(); checks++;
      if (got !== exp) begin failures++; $display("FAIL refresh_period c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_single_write();
    obs_t got, exp;
    logic wen, bsy;
    do_reset(1'b1);
    for (int c = 1; c <= 12; c++) begin
      wr_req   = (c <= 3) || (c >= 10);
      wr_ready = !((c >= 4) && (c <= 8));
      wen = (c <= 3) || (c >= 10);
      bsy = (c <= 8) || (c >= 10);
      exp_q.push_back(mk(wen, 0, 0, 0, bsy, 0, bsy ? 1 : 0, 0));
      cycle();
      exp = exp_q.pop_front();
      got = obs_a(); checks++;
      if (got !== exp) begin failures++; $display("FAIL single_write c=%0d got=%h exp=%h", c, got, exp); end
    end
    wr_req = 1'b0; wr_ready = 1'b1;
  endtask

  task automatic test_round_robin();
    grant_t g, e;
    int prev, cur, start, run;
    do_reset(1'b1);
    grant_q.push_back({2'd1, 8'd1,  8'd8});
    grant_q.push_back({2'd2, 8'd11, 8'd8});
    grant_q.push_back({2'd1, 8'd21, 8'd8});
    prev = 0; start = 0; run = 0;
    for (int c = 1; c <= 34; c++) begin
      wr_req = (c < 30); rd_req = (c < 30);
      wr_ready = !a_wr_en; rd_ready = !a_rd_en;
      cycle();
      checks++;
      if (a_wr_en && a_rd_en) begin
        failures++; $display("FAIL rr_overlap c=%0d wr_en=%b rd_en=%b required at most one", c, a_wr_en, a_rd_en);
      end
      cur = a_wr_en ? 1 : (a_rd_en ? 2 : 0);
      if ((cur != prev) && (prev != 0)) begin
        g = {2'(prev), 8'(start), 8'(run)};
        checks++;
        if (grant_q.size() == 0) begin
          failures++; $display("FAIL rr_grant unexpected grant side=%0d start=%0d len=%0d", g.side, g.start, g.len);
        end else begin
          e = grant_q.pop_front();
          if (g !== e) begin
            failures++;
            $display("FAIL rr_grant got side=%0d start=%0d len=%0d exp side=%0d start=%0d len=%0d",
                     g.side, g.start, g.len, e.side, e.start, e.len);
          end
        end
      end
      if ((cur != 0) && (cur == prev)) run++;
      else if (cur != 0) begin start = c; run = 1; end
      prev = cur;
    end
    checks++;
    if (grant_q.size() != 0) begin
      failures++; $display("FAIL rr_missing grants_left=%0d required=0", grant_q.size());
      grant_q.delete();
    end
    wr_req = 1'b0; rd_req = 1'b0; wr_ready = 1'b1; rd_ready = 1'b1;
  endtask

  task automatic test_refresh_in_grant();
    obs_t got, exp;
    logic bsy;
    do_reset(1'b1);
    for (int c = 1; c <= 47; c++) begin
      wr_req = (c <= 30); wr_ready = 1'b1;
      bsy = (c <= 31) || ((c >= 41) && (c <= 47));
      exp_q.push_back(mk(c <= 30, 0, c == 21, 0, bsy, 0, (c <= 31) ? 1 : 0, c == 41));
      cycle();
      exp = exp_q.pop_front();
      got = obs_r(); checks++;
      if (got !== exp) begin failures++; $display("FAIL refresh_in_grant c=%0d got=%h exp=%h", c, got, exp); end
    end
    wr_req = 1'b0;
  endtask

  task automatic test_refresh_in_release();
    obs_t got, exp;
    logic bsy;
    do_reset(1'b1);
    for (int c = 1; c <= 50; c++) begin
      rd_req   = (c <= 9);
      rd_ready = !((c >= 10) && (c <= 40));
      bsy = (c <= 40) || ((c >= 42) && (c <= 48));
      exp_q.push_back(mk(0, c <= 9, 0, 0, bsy, c == 40, (c <= 40) ? 2 : 0, c == 42));
      cycle();
      exp = exp_q.pop_front();
      got = obs_r(); checks++;
      if (got !== exp) begin failures++; $display("FAIL refresh_in_release c=%0d got=%h exp=%h", c, got, exp); end
    end
    rd_req = 1'b0; rd_ready = 1'b1;
  endtask

  task automatic test_expiry_vs_decision();
    obs_t got, exp;
    do_reset(1'b1);
    for (int c = 1; c <= 24; c++) begin
      wr_req = (c >= 20);
      exp_q.push_back(mk(c >= 20, 0, c == 21, 0, c >= 20, 0, (c >= 20) ? 1 : 0, 0));
      cycle();
      exp = exp_q.pop_front();
      got = obs_r(); checks++;
      if (got !== exp) begin failures++; $display("FAIL expiry_vs_decision c=%0d got=%h exp=%h", c, got, exp); end
    end
    wr_req = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    do_reset(1'b1);
    wr_req = 1'b1;
    repeat (3) cycle();
    exp = mk(1, 0, 0, 0, 1, 0, 1, 0);
    got = obs_a(); checks++;
    if (got !== exp) begin failures++; $display("FAIL async_pre_grant got=%h exp=%h", got, exp); end
    #2 rst = 1'b0;
    #1;
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
    got = obs_a(); checks++;
    if (got !== exp) begin failures++; $display("FAIL async_reset_now got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cycle();
    exp = mk(1, 0, 0, 0, 1, 0, 1, 0);
    got = obs_a(); checks++;
    if (got !== exp) begin failures++; $display("FAIL async_first_grant got=%h exp=%h", got, exp); end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_ready = 1'b1; rd_ready = 1'b1;
    wr_command = WCMD; wr_addr = WADDR; wr_bank = WBANK;
    rd_command = RCMD; rd_addr = RADDR; rd_bank = RBANK;
    test_reset();
    test_init_gate();
    test_refresh_period();
    test_single_write();
    test_round_robin();
    test_refresh_in_grant();
    test_refresh_in_release();
    test_expiry_vs_decision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
